// File: rtl/timer_pkg.sv
// Shared definitions for the machine timer and its neighbours on the
// data-memory bus.
//   - mem_mode encodings (funct3 of loads/stores), shared with data_mem
//   - register offsets inside the 32-byte timer window
//   - ctrl_t: packed layout of the CTRL register as it is read back
package timer_pkg;

  // Access size/sign encodings, funct3 of the load/store instruction.
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Register offsets (addr[4:0]).
  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_STATUS      = 5'h14;
  // Highest implemented offset; 0x18/0x1C are reserved.
  localparam logic [4:0] OFF_LAST        = OFF_STATUS;

  // Widest prescaler that fits in CTRL[31:8].
  localparam int CTRL_PRESC_MAX_W = 24;

  // CTRL as seen on the bus. The presc field is always the full 24 bits;
  // bits above the configured prescaler width are held at zero so the
  // struct can be read back verbatim.
  typedef struct packed {
    logic [CTRL_PRESC_MAX_W-1:0] presc;
    logic [5:0]                  rsvd;
    logic                        ie;
    logic                        en;
  } ctrl_t;

endpackage

// File: rtl/timer_periph_if.sv
// Load/store bus between the core's memory stage (master) and a
// memory-mapped responder such as the timer (slave).
//   rd_en/wr_en/addr/wdata/mem_mode : request from the memory stage
//   hit     : combinational address-window match from the responder
//   rdata   : combinational read data from the responder
//   acc_err : registered one-cycle illegal-access pulse from the responder
interface timer_periph_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  mem_mode;
  logic        hit;
  logic [31:0] rdata;
  logic        acc_err;

  modport master (
    output rd_en, wr_en, addr, wdata, mem_mode,
    input  hit, rdata, acc_err
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata, mem_mode,
    output hit, rdata, acc_err
  );
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for the machine timer: divides clk by (presc+1) while enabled.
//   clk, rst : clock, synchronous active-high reset
//   en       : count enable; when low the count is held
//   presc    : divide value; 0 means a tick every cycle
//   clear    : restart the count at zero (CTRL was written)
//   tick     : one-cycle pulse, mtime increments on it
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clear,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt_q;
  logic [PRESC_W-1:0] presc_cnt_d;

  // The tick is judged on the pre-edge count and settings, so a CTRL write
  // in a ticking cycle still lets that tick through; the count restarts.
  assign tick = en && (presc_cnt_q == presc);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (clear) begin
      presc_cnt_d = '0;
    end else if (en) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped machine timer on the data-memory load/store bus.
// 64-bit prescaled mtime, 64-bit mtimecmp, CTRL/STATUS, and a registered
// timer interrupt for the CSR unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave end of the load/store bus (request in; hit, rdata,
//              acc_err out)
//   t_intr   : registered ie & (mtime >= mtimecmp)
module timer_periph
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          PRESC_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  timer_periph_if.slave  bus,
  output logic           t_intr
);

  localparam logic [CTRL_PRESC_MAX_W-1:0] PRESC_MASK =
    (CTRL_PRESC_MAX_W'(1) << PRESC_W) - CTRL_PRESC_MAX_W'(1);

  logic [63:0] mtime_q,     mtime_d;
  logic [63:0] mtimecmp_q,  mtimecmp_d;
  ctrl_t       ctrl_q,      ctrl_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic        ovf_q,       ovf_d;
  logic        t_intr_q,    t_intr_d;
  logic        acc_err_q,   acc_err_d;

  logic [4:0]  offset;
  logic        access;
  logic        legal;
  logic        rd_ok;
  logic        wr_ok;
  logic        pend;
  logic        tick;
  logic        ctrl_wr;
  logic [31:0] rdata_c;

  assign offset  = bus.addr[4:0];
  assign bus.hit = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign access  = bus.hit && (bus.rd_en || bus.wr_en);
  assign legal   = access && (bus.mem_mode == MODE_W) &&
                   (bus.addr[1:0] == 2'b00) && (offset <= OFF_LAST);
  assign rd_ok   = legal && bus.rd_en;
  assign wr_ok   = legal && bus.wr_en;
  assign pend    = (mtime_q >= mtimecmp_q);
  assign ctrl_wr = wr_ok && (offset == OFF_CTRL);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl_q.en),
    .presc (ctrl_q.presc[PRESC_W-1:0]),
    .clear (ctrl_wr),
    .tick  (tick)
  );

  // Read mux: pre-edge values, so a simultaneous write shows the old value.
  always_comb begin
    rdata_c = '0;
    if (rd_ok) begin
      unique case (offset)
        OFF_MTIME_LO:    rdata_c = mtime_q[31:0];
        OFF_MTIME_HI:    rdata_c = shadow_hi_q;
        OFF_MTIMECMP_LO: rdata_c = mtimecmp_q[31:0];
        OFF_MTIMECMP_HI: rdata_c = mtimecmp_q[63:32];
        OFF_CTRL:        rdata_c = ctrl_q;
        OFF_STATUS:      rdata_c = {30'd0, ovf_q, pend};
        default:         rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata   = rdata_c;
  assign bus.acc_err = acc_err_q;
  assign t_intr      = t_intr_q;

  always_comb begin
    logic time_wr;
    logic ovf_set;

    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    ctrl_d      = ctrl_q;
    shadow_hi_d = shadow_hi_q;
    ovf_d       = ovf_q;
    time_wr     = 1'b0;
    ovf_set     = 1'b0;

    acc_err_d = access && !legal;
    t_intr_d  = ctrl_q.ie && pend;

    // Latch the upper half with the lower so a LO-then-HI read pair is
    // coherent across a carry.
    if (rd_ok && (offset == OFF_MTIME_LO)) begin
      shadow_hi_d = mtime_q[63:32];
    end

    if (wr_ok) begin
      unique case (offset)
        OFF_MTIME_LO: begin
          mtime_d[31:0] = bus.wdata;
          time_wr       = 1'b1;
        end
        OFF_MTIME_HI: begin
          mtime_d[63:32] = bus.wdata;
          time_wr        = 1'b1;
        end
        OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = bus.wdata;
        OFF_MTIMECMP_HI: mtimecmp_d[63:32] = bus.wdata;
        OFF_CTRL: begin
          ctrl_d.presc = bus.wdata[31:8] & PRESC_MASK;
          ctrl_d.rsvd  = '0;
          ctrl_d.ie    = bus.wdata[1];
          ctrl_d.en    = bus.wdata[0];
        end
        OFF_STATUS: begin
          if (bus.wdata[1]) begin
            ovf_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A software write to either half of mtime swallows that cycle's tick.
    if (tick && !time_wr) begin
      mtime_d = mtime_q + 64'd1;
      ovf_set = (mtime_q == '1);
    end

    // A wrap in the same cycle as a W1C keeps the flag set.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      ctrl_q      <= '0;
      shadow_hi_q <= '0;
      ovf_q       <= 1'b0;
      t_intr_q    <= 1'b0;
      acc_err_q   <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ctrl_q      <= ctrl_d;
      shadow_hi_q <= shadow_hi_d;
      ovf_q       <= ovf_d;
      t_intr_q    <= t_intr_d;
      acc_err_q   <= acc_err_d;
    end
  end

endmodule

// File: tb/tb_timer_periph.sv
// Bench for timer_periph: directed bus transactions, a behavioural model
// checked every cycle, and literal expectations for key moments.
module tb_timer_periph;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_intr;

  timer_periph_if bus_if ();

  timer_periph #(
    .BASE_ADDR (BASE),
    .PRESC_W   (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_if),
    .t_intr (t_intr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_ie, m_ovf, m_intr, m_err;
  logic [7:0]  m_presc;
  logic [31:0] m_shadow;
  longint unsigned m_encnt; // enabled cycles since the last CTRL write

  function automatic logic m_legal(input logic rd, input logic wr, input logic [31:0] a,
                                   input logic [2:0] md);
    return (a[31:5] == BASE[31:5]) && (rd || wr) && (md == MODE_W) &&
           (a[1:0] == 2'b00) && (a[4:0] <= 5'h14);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] off);
    case (off)
      5'h00:   return m_mtime[31:0];
      5'h04:   return m_shadow;
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return {16'h0, m_presc, 6'h0, m_ie, m_en};
      5'h14:   return {30'h0, m_ovf, (m_mtime >= m_cmp)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic        rd, wr, lg, hitv, tick, wrote;
    logic [31:0] a, d;
    logic [4:0]  off;
    logic [63:0] nt;
    rd = bus_if.rd_en; wr = bus_if.wr_en; a = bus_if.addr; d = bus_if.wdata;
    off = a[4:0];
    if (rst) begin
      m_mtime = 0; m_cmp = '1; m_en = 0; m_ie = 0; m_presc = 0;
      m_shadow = 0; m_ovf = 0; m_intr = 0; m_err = 0; m_encnt = 0;
      m_valid = 1'b1;
      return;
    end
    hitv = (a[31:5] == BASE[31:5]);
    lg   = m_legal(rd, wr, a, bus_if.mem_mode);
    tick = m_en && ((m_encnt % (longint'(m_presc) + 1)) == longint'(m_presc));
    m_err  = hitv && (rd || wr) && !lg;
    m_intr = m_ie && (m_mtime >= m_cmp);
    if (lg && rd && off == 5'h00) m_shadow = m_mtime[63:32];
    nt = m_mtime;
    wrote = 0;
    if (m_en) m_encnt++;
    if (lg && wr) begin
      case (off)
        5'h00: begin nt[31:0] = d; wrote = 1; end
        5'h04: begin nt[63:32] = d; wrote = 1; end
        5'h08: m_cmp[31:0] = d;
        5'h0C: m_cmp[63:32] = d;
        5'h10: begin m_en = d[0]; m_ie = d[1]; m_presc = d[15:8]; m_encnt = 0; end
        5'h14: if (d[1]) m_ovf = 0;
        default: ;
      endcase
    end
    if (tick && !wrote) begin
      if (m_mtime == '1) m_ovf = 1;
      nt = m_mtime + 1;
    end
    m_mtime = nt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // One compare process: every cycle, outputs against the model.
  initial forever begin
    @(negedge clk);
    if (m_valid && !rst) begin
      chk("hit", bus_if.hit, (bus_if.addr[31:5] == BASE[31:5]));
      chk("rdata", bus_if.rdata,
          (m_legal(bus_if.rd_en, bus_if.wr_en, bus_if.addr, bus_if.mem_mode) && bus_if.rd_en)
            ? m_read(bus_if.addr[4:0]) : 32'h0);
      chk("acc_err", bus_if.acc_err, m_err);
      chk("t_intr", t_intr, m_intr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] md);
    @(posedge clk);
    #1;
    bus_if.rd_en = rd; bus_if.wr_en = wr; bus_if.addr = a;
    bus_if.wdata = d; bus_if.mem_mode = md;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 32'h0, MODE_W);
  endtask

  task automatic wr32(input logic [4:0] off, input logic [31:0] d);
    drive(0, 1, BASE + {27'h0, off}, d, MODE_W);
    $display("[TB] write off=%h data=%h", off, d);
  endtask

  task automatic rdchk(input logic [4:0] off, input logic [31:0] exp, input string name);
    drive(1, 0, BASE + {27'h0, off}, 32'h0, MODE_W);
    @(negedge clk);
    chk(name, bus_if.rdata, exp);
    $display("[TB] read  off=%h data=%h exp=%h", off, bus_if.rdata, exp);
  endtask

  typedef struct { logic [4:0] off; logic [31:0] val; } rv_t;
  rv_t reset_tbl[6] = '{'{5'h00, 32'h0}, '{5'h04, 32'h0}, '{5'h08, 32'hFFFF_FFFF},
                        '{5'h0C, 32'hFFFF_FFFF}, '{5'h10, 32'h0}, '{5'h14, 32'h0}};

  initial begin
    bit found;
    bus_if.rd_en = 0; bus_if.wr_en = 0; bus_if.addr = 0;
    bus_if.wdata = 0; bus_if.mem_mode = MODE_W;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    foreach (reset_tbl[i]) rdchk(reset_tbl[i].off, reset_tbl[i].val, "reset_read");
    chk("reset_t_intr", t_intr, 1'b0);

    // Outside the window: no hit, no error
    drive(1, 0, 32'h0000_1000, 32'h0, MODE_W);
    @(negedge clk);
    chk("miss_hit", bus_if.hit, 1'b0);
    idle(1);
    @(negedge clk);
    chk("miss_acc_err", bus_if.acc_err, 1'b0);

    // Prescaler: presc=3 -> one tick every 4 cycles
    wr32(OFF_CTRL, 32'h0000_0301);
    idle(40);
    rdchk(OFF_MTIME_LO, 32'd10, "presc_mtime_10");
    idle(3);
    rdchk(OFF_MTIME_LO, 32'd11, "presc_mtime_11");
    rdchk(OFF_CTRL, 32'h0000_0301, "ctrl_readback");

    // Compare / interrupt
    wr32(OFF_MTIMECMP_HI, 32'h0);
    wr32(OFF_MTIMECMP_LO, 32'd20);
    wr32(OFF_CTRL, 32'h0000_0003);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive(1, 0, BASE, 32'h0, MODE_W);
      @(negedge clk);
      if (bus_if.rdata == 32'd20) begin
        found = 1;
        chk("intr_low_at_20", t_intr, 1'b0);
        drive(1, 0, BASE, 32'h0, MODE_W);
        @(negedge clk);
        chk("intr_high_after_20", t_intr, 1'b1);
        $display("[TB] mtime reached 20, t_intr=%b next cycle", t_intr);
      end
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL intr_wait: mtime never read 20 within 60 cycles");
    end
    wr32(OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
    idle(1);
    @(negedge clk);
    chk("intr_hold_one_cycle", t_intr, 1'b1);
    idle(1);
    @(negedge clk);
    chk("intr_fall", t_intr, 1'b0);

    // Wrap and overflow flag
    wr32(OFF_MTIME_HI, 32'hFFFF_FFFF);
    wr32(OFF_MTIME_LO, 32'hFFFF_FFFE);
    idle(2);
    rdchk(OFF_STATUS, 32'h2, "status_ovf");
    wr32(OFF_STATUS, 32'h2);
    rdchk(OFF_STATUS, 32'h0, "status_cleared");

    // Shadow: LO read before a carry, HI read after it
    wr32(OFF_CTRL, 32'h0);
    wr32(OFF_MTIME_HI, 32'd5);
    wr32(OFF_MTIME_LO, 32'hFFFF_FFFF);
    wr32(OFF_CTRL, 32'h1);
    rdchk(OFF_MTIME_LO, 32'hFFFF_FFFF, "shadow_lo");
    rdchk(OFF_MTIME_HI, 32'd5, "shadow_hi_5");
    rdchk(OFF_MTIME_LO, 32'd1, "shadow_lo_after");
    rdchk(OFF_MTIME_HI, 32'd6, "shadow_hi_6");

    // Simultaneous read and write shows the old value
    drive(1, 1, BASE + 32'h08, 32'h55, MODE_W);
    @(negedge clk);
    chk("rdwr_old_value", bus_if.rdata, 32'hFFFF_FFFF);
    rdchk(OFF_MTIMECMP_LO, 32'h55, "rdwr_new_value");

    // Illegal accesses
    drive(0, 1, BASE + 32'h08, 32'h12, MODE_B);
    @(negedge clk);
    chk("byte_st_no_err_yet", bus_if.acc_err, 1'b0);
    idle(1);
    @(negedge clk);
    chk("byte_st_err", bus_if.acc_err, 1'b1);
    idle(1);
    @(negedge clk);
    chk("byte_st_err_gone", bus_if.acc_err, 1'b0);
    rdchk(OFF_MTIMECMP_LO, 32'h55, "byte_st_ignored");
    drive(1, 0, BASE + 32'h18, 32'h0, MODE_W);
    @(negedge clk);
    chk("rsvd_rdata", bus_if.rdata, 32'h0);
    idle(1);
    @(negedge clk);
    chk("rsvd_err", bus_if.acc_err, 1'b1);
    idle(1);
    @(negedge clk);
    chk("rsvd_err_gone", bus_if.acc_err, 1'b0);
    $display("[TB] illegal accesses done");

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
